multicycle_core: RTL and testbench

Parametrised multicycle RV32I-subset core: control FSM, register file, ALU and instruction/data sequencing in one block, with a single stallable request/ready memory port in place of an internal memory array. It sits between the top level and an external unified instruction/data memory. It also exposes debug and retire-count outputs for the bench.

---
 rtl/multicycle_core.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core with a single stallable request/ready memory port.
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB); traps park the core in HALT until reset.
module multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              halted,
    output logic [1:0]        trap_cause,
    output logic [31:0]       dbg_pc,
    output logic [31:0]       dbg_instr,
    output logic [31:0]       retired
);
    localparam int RI_W = $clog2(NUM_REGS);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [2:0]  r_state;
    logic [31:0] r_pc, r_old_pc, r_ir, r_a, r_b, r_alu_out, r_data, r_retired;
    logic [1:0]  r_trap;
    logic [31:0] r_rf [NUM_REGS];

    logic [6:0]  w_opcode, w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2, w_shamt;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
    logic [31:0] w_rs1_val, w_rs2_val, w_op2, w_sra, w_alu, w_result;
    logic [31:0] w_pc4, w_br_tgt, w_jmp_tgt, w_ls_addr, w_wb_val;
    logic        w_is_br, w_is_jal, w_is_jalr, w_is_lw, w_is_sw;
    logic        w_legal, w_use_rd, w_use_rs1, w_use_rs2, w_bad_reg, w_illegal, w_br_taken;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_f3     = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_f7     = r_ir[31:25];

    assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_imm_u = {r_ir[31:12], 12'b0};

    assign w_is_br   = (w_opcode == OP_BR);
    assign w_is_jal  = (w_opcode == OP_JAL);
    assign w_is_jalr = (w_opcode == OP_JALR);
    assign w_is_lw   = (w_opcode == OP_LW);
    assign w_is_sw   = (w_opcode == OP_SW);

    always_comb begin
        w_legal   = 1'b0;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_legal   = (w_f7 == 7'b0000000) ||
                            ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OP_I: begin
                if (w_f3 == 3'b001)      w_legal = (w_f7 == 7'b0000000);
                else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                else                     w_legal = 1'b1;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
            end
            OP_LW:    begin w_legal = (w_f3 == 3'b010); w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
            OP_SW:    begin w_legal = (w_f3 == 3'b010); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_BR:    begin w_legal = !w_f3[1]; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_JAL:   begin w_legal = 1'b1; w_use_rd = 1'b1; end
            OP_JALR:  begin w_legal = (w_f3 == 3'b000); w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
            OP_LUI, OP_AUIPC: begin w_legal = 1'b1; w_use_rd = 1'b1; end
            default: ;
        endcase
    end

    // Only the RV32E configuration can see an out-of-range register index.
    assign w_bad_reg = (NUM_REGS == 16) &&
                       ((w_use_rd && w_rd[4]) || (w_use_rs1 && w_rs1[4]) || (w_use_rs2 && w_rs2[4]));
    assign w_illegal = !w_legal || w_bad_reg;

    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1[RI_W-1:0]];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2[RI_W-1:0]];

    assign w_op2   = (w_opcode == OP_R) ? r_b : w_imm_i;
    assign w_shamt = w_op2[4:0];
    assign w_sra   = $signed(r_a) >>> w_shamt;

    always_comb begin
        case (w_f3)
            3'b000:  w_alu = ((w_opcode == OP_R) && w_f7[5]) ? r_a - w_op2 : r_a + w_op2;
            3'b001:  w_alu = r_a << w_shamt;
            3'b010:  w_alu = {31'b0, $signed(r_a) < $signed(w_op2)};
            3'b011:  w_alu = {31'b0, r_a < w_op2};
            3'b100:  w_alu = r_a ^ w_op2;
            3'b101:  w_alu = w_f7[5] ? w_sra : r_a >> w_shamt;
            3'b110:  w_alu = r_a | w_op2;
            default: w_alu = r_a & w_op2;
        endcase
    end

    always_comb begin
        case (w_f3)
            3'b000:  w_br_taken = (r_a == r_b);
            3'b001:  w_br_taken = (r_a != r_b);
            3'b100:  w_br_taken = $signed(r_a) < $signed(r_b);
            3'b101:  w_br_taken = $signed(r_a) >= $signed(r_b);
            default: w_br_taken = 1'b0;
        endcase
    end

    assign w_result  = (w_opcode == OP_LUI)   ? w_imm_u :
                       (w_opcode == OP_AUIPC) ? r_old_pc + w_imm_u : w_alu;
    assign w_pc4     = r_old_pc + 32'd4;
    assign w_br_tgt  = r_old_pc + w_imm_b;
    assign w_jmp_tgt = w_is_jalr ? ((r_a + w_imm_i) & ~32'd1) : r_old_pc + w_imm_j;
    assign w_ls_addr = r_a + (w_is_sw ? w_imm_s : w_imm_i);
    assign w_wb_val  = w_is_lw ? r_data : r_alu_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_old_pc  <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
            r_data    <= '0;
            r_retired <= '0;
            r_trap    <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (mem_ready) begin
                    r_ir     <= mem_rdata;
                    r_old_pc <= r_pc;
                    r_state  <= S_DECODE;
                end
                S_DECODE: begin
                    r_a <= w_rs1_val;
                    r_b <= w_rs2_val;
                    if (w_illegal) begin
                        r_trap  <= 2'b01;
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_is_br) begin
                        if (w_br_taken && (w_br_tgt[1:0] != 2'b00)) begin
                            r_trap  <= 2'b11;
                            r_state <= S_HALT;
                        end else begin
                            r_pc      <= w_br_taken ? w_br_tgt : w_pc4;
                            r_retired <= r_retired + 32'd1;
                            r_state   <= S_FETCH;
                        end
                    end else if (w_is_jal || w_is_jalr) begin
                        if (w_jmp_tgt[1:0] != 2'b00) begin
                            r_trap  <= 2'b11;
                            r_state <= S_HALT;
                        end else begin
                            r_alu_out <= w_pc4;
                            r_pc      <= w_jmp_tgt;
                            r_state   <= S_WB;
                        end
                    end else if (w_is_lw || w_is_sw) begin
                        if (w_ls_addr[1:0] != 2'b00) begin
                            r_trap  <= 2'b10;
                            r_state <= S_HALT;
                        end else begin
                            r_alu_out <= w_ls_addr;
                            r_pc      <= w_pc4;
                            r_state   <= S_MEM;
                        end
                    end else begin
                        r_alu_out <= w_result;
                        r_pc      <= w_pc4;
                        r_state   <= S_WB;
                    end
                end
                S_MEM: if (mem_ready) begin
                    if (w_is_sw) begin
                        r_retired <= r_retired + 32'd1;
                        r_state   <= S_FETCH;
                    end else begin
                        r_data  <= mem_rdata;
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    r_retired <= r_retired + 32'd1;
                    r_state   <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && (r_state == S_WB) && (w_rd != 5'd0))
            r_rf[w_rd[RI_W-1:0]] <= w_wb_val;
    end

    // Reset gates the request directly so a pending transfer is abandoned immediately.
    assign mem_req    = !reset && ((r_state == S_FETCH) || (r_state == S_MEM));
    assign mem_we     = (r_state == S_MEM) && w_is_sw;
    assign mem_addr   = (r_state == S_MEM) ? r_alu_out[ADDR_W-1:0] : r_pc[ADDR_W-1:0];
    assign mem_wdata  = r_b;
    assign halted     = (r_state == S_HALT);
    assign trap_cause = r_trap;
    assign dbg_pc     = r_pc;
    assign dbg_instr  = r_ir;
    assign retired    = r_retired;
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: timing, program results, stalls, branches/calls,
// traps, RV32E register-range check and reset during a stalled store.
module tb_multicycle_core;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        halted;
    logic [1:0]  trap_cause;
    logic [31:0] dbg_pc, dbg_instr, retired;

    logic        rst16;
    logic        mem_req16, mem_we16, halted16;
    logic        mem_ready16 = 1'b1;
    logic [31:0] mem_rdata16 = 32'h0020_88B3;
    logic [31:0] mem_addr16, mem_wdata16, dbg_pc16, dbg_instr16, retired16;
    logic [1:0]  trap16;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [256];
    logic        load_we = 1'b0;
    logic [31:0] load_addr, load_data;
    int          store_count = 0;
    logic [31:0] last_st_addr, last_st_data;
    logic [31:0] fetch_log [64];
    int          fetch_cyc [64];
    int          fetch_n = 0;
    int          cyc = 0;
    logic        hold = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    int          stall_checks = 0;
    int          stall_viol = 0;

    int          ready_mode = 0;
    logic        armed;
    int          wait_left;
    int          sc0, f0;
    logic [31:0] exp_f [13];

    always #5 clk = ~clk;

    multicycle_core #(.RESET_PC(32'h100), .NUM_REGS(32), .ADDR_W(32)) u_dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .halted(halted),
        .trap_cause(trap_cause), .dbg_pc(dbg_pc), .dbg_instr(dbg_instr), .retired(retired)
    );

    multicycle_core #(.RESET_PC(32'h100), .NUM_REGS(16), .ADDR_W(32)) u_dut16 (
        .clk(clk), .reset(rst16), .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16),
        .mem_wdata(mem_wdata16), .mem_ready(mem_ready16), .mem_rdata(mem_rdata16), .halted(halted16),
        .trap_cause(trap16), .dbg_pc(dbg_pc16), .dbg_instr(dbg_instr16), .retired(retired16)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_we) begin
            mem[load_addr[9:2]] <= load_data;
        end else if (mem_req && mem_ready) begin
            if (mem_we) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                store_count  <= store_count + 1;
                last_st_addr <= mem_addr;
                last_st_data <= mem_wdata;
            end else begin
                fetch_log[fetch_n & 63] <= mem_addr;
                fetch_cyc[fetch_n & 63] <= cyc;
                fetch_n <= fetch_n + 1;
            end
        end
        if (reset) begin
            hold <= 1'b0;
        end else begin
            if (hold) begin
                stall_checks <= stall_checks + 1;
                if (!mem_req || mem_addr !== h_addr || mem_we !== h_we ||
                    (h_we && mem_wdata !== h_wdata))
                    stall_viol <= stall_viol + 1;
            end
            hold    <= mem_req && !mem_ready;
            h_addr  <= mem_addr;
            h_we    <= mem_we;
            h_wdata <= mem_wdata;
        end
    end

    // Ready generator: 0 = always ready, 1 = random 0-5 wait cycles per transfer, 2 = held low.
    initial begin
        mem_ready = 1'b1;
        armed     = 1'b0;
        wait_left = 0;
        forever begin
            @(negedge clk);
            if (ready_mode == 0) begin
                mem_ready = 1'b1;
                armed     = 1'b0;
            end else if (ready_mode == 2) begin
                mem_ready = 1'b0;
                armed     = 1'b0;
            end else begin
                if (armed && mem_ready) armed = 1'b0;
                if (mem_req) begin
                    if (!armed) begin
                        wait_left = $urandom_range(0, 5);
                        armed     = 1'b1;
                    end
                    if (wait_left == 0) begin
                        mem_ready = 1'b1;
                    end else begin
                        mem_ready = 1'b0;
                        wait_left--;
                    end
                end else begin
                    mem_ready = 1'b0;
                    armed     = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_addr = a;
        load_data = d;
        load_we   = 1'b1;
        tick();
        load_we   = 1'b0;
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    task automatic run_until_halt(input int max_cyc);
        int n = 0;
        while (!halted && n < max_cyc) begin
            tick();
            n++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        rst16 = 1'b1;
        exp_f = '{32'h100, 32'h104, 32'h108, 32'h104, 32'h108, 32'h104, 32'h108,
                  32'h10C, 32'h11C, 32'h120, 32'h110, 32'h114, 32'h118};
        repeat (2) tick();

        // RV32E: x17 is out of range
        rst16 = 1'b0;
        tick();
        chk("e16_halt_early", 32'(halted16), 32'd0);
        tick();
        chk("e16_halt", 32'(halted16), 32'd1);
        chk("e16_trap", 32'(trap16), 32'd1);

        // Straight-line program
        load(32'h100, 32'h0050_0093);
        load(32'h104, 32'hFFD0_0113);
        load(32'h108, 32'h0020_81B3);
        load(32'h10C, 32'h0011_2233);
        load(32'h110, 32'h0430_2023);
        load(32'h114, 32'h0400_2283);
        load(32'h118, 32'h0450_2223);
        load(32'h11C, 32'h0440_2423);
        load(32'h120, 32'hFFFF_FFFF);
        load(32'h40, 32'h0);
        load(32'h44, 32'h0);
        load(32'h48, 32'h0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_pc", dbg_pc, 32'h100);
        chk("rst_ir", dbg_instr, 32'h0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_trap", 32'(trap_cause), 32'd0);
        sc0 = store_count;
        reset = 1'b0;
        #1;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, 32'h100);
        chk("first_we", 32'(mem_we), 32'd0);
        repeat (3) tick();
        chk("ret_before_wb", retired, 32'd0);
        tick();
        chk("ret_first_wb", retired, 32'd1);
        repeat (20) tick();
        chk("ret_at_24", retired, 32'd5);
        tick();
        chk("ret_at_25", retired, 32'd6);
        chk("st_count", 32'(store_count - sc0), 32'd1);
        chk("st_addr", last_st_addr, 32'h40);
        chk("st_data", last_st_data, 32'd2);
        run_until_halt(100);
        chk("p1_trap", 32'(trap_cause), 32'd1);
        chk("p1_retired", retired, 32'd8);
        chk("p1_pc", dbg_pc, 32'h120);
        chk("p1_ir", dbg_instr, 32'hFFFF_FFFF);
        chk("p1_x5", rd_mem(32'h44), 32'd2);
        chk("p1_x4", rd_mem(32'h48), 32'd1);

        // Same program under random wait states
        reset = 1'b1;
        load(32'h40, 32'h0);
        load(32'h44, 32'h0);
        load(32'h48, 32'h0);
        ready_mode = 1;
        sc0 = store_count;
        reset = 1'b0;
        run_until_halt(1500);
        chk("rs_retired", retired, 32'd8);
        chk("rs_x3", rd_mem(32'h40), 32'd2);
        chk("rs_x5", rd_mem(32'h44), 32'd2);
        chk("rs_x4", rd_mem(32'h48), 32'd1);
        chk("rs_stores", 32'(store_count - sc0), 32'd3);
        chk("rs_stall_seen", 32'(stall_checks > 0), 32'd1);
        chk("rs_stall_stable", 32'(stall_viol), 32'd0);

        // Countdown loop plus call/return
        reset = 1'b1;
        ready_mode = 0;
        load(32'h100, 32'h0030_0093);
        load(32'h104, 32'hFFF0_8093);
        load(32'h108, 32'hFE00_9EE3);
        load(32'h10C, 32'h0100_02EF);
        load(32'h110, 32'h0450_2023);
        load(32'h114, 32'h0470_2223);
        load(32'h118, 32'hFFFF_FFFF);
        load(32'h11C, 32'h0070_0313);
        load(32'h120, 32'h0002_83E7);
        load(32'h40, 32'h0);
        load(32'h44, 32'h0);
        f0 = fetch_n;
        reset = 1'b0;
        run_until_halt(200);
        chk("br_fetches", 32'(fetch_n - f0), 32'd13);
        for (int i = 0; i < 13; i++)
            chk($sformatf("br_fetch%0d", i), fetch_log[(f0 + i) & 63], exp_f[i]);
        chk("br_taken_cyc", 32'(fetch_cyc[(f0 + 3) & 63] - fetch_cyc[(f0 + 2) & 63]), 32'd3);
        chk("br_ntaken_cyc", 32'(fetch_cyc[(f0 + 7) & 63] - fetch_cyc[(f0 + 6) & 63]), 32'd3);
        chk("jal_cyc", 32'(fetch_cyc[(f0 + 8) & 63] - fetch_cyc[(f0 + 7) & 63]), 32'd4);
        chk("jal_link", rd_mem(32'h40), 32'h110);
        chk("jalr_link", rd_mem(32'h44), 32'h124);
        chk("br_retired", retired, 32'd12);

        // Misaligned load
        reset = 1'b1;
        load(32'h100, 32'h0420_2283);
        reset = 1'b0;
        repeat (2) tick();
        chk("mal_halt_early", 32'(halted), 32'd0);
        tick();
        chk("mal_halt", 32'(halted), 32'd1);
        chk("mal_trap", 32'(trap_cause), 32'd2);
        chk("mal_retired", retired, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("mal_no_req", 32'(mem_req), 32'd0);
            tick();
        end

        // Illegal encoding
        reset = 1'b1;
        load(32'h100, 32'hFFFF_FFFF);
        reset = 1'b0;
        tick();
        chk("ill_halt_early", 32'(halted), 32'd0);
        tick();
        chk("ill_halt", 32'(halted), 32'd1);
        chk("ill_trap", 32'(trap_cause), 32'd1);

        // JALR to a misaligned target
        reset = 1'b1;
        load(32'h100, 32'h1020_0093);
        load(32'h104, 32'h0000_8067);
        reset = 1'b0;
        repeat (6) tick();
        chk("jt_halt_early", 32'(halted), 32'd0);
        tick();
        chk("jt_halt", 32'(halted), 32'd1);
        chk("jt_trap", 32'(trap_cause), 32'd3);
        chk("jt_pc", dbg_pc, 32'h104);
        chk("jt_retired", retired, 32'd1);

        // Reset while a store is stalled
        reset = 1'b1;
        load(32'h100, 32'h0090_0093);
        load(32'h104, 32'h0410_2023);
        load(32'h40, 32'h0);
        sc0 = store_count;
        reset = 1'b0;
        repeat (7) tick();
        ready_mode = 2;
        repeat (3) tick();
        chk("stall_req", 32'(mem_req), 32'd1);
        chk("stall_we", 32'(mem_we), 32'd1);
        chk("stall_addr", mem_addr, 32'h40);
        chk("stall_wdata", mem_wdata, 32'd9);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_drops_req", 32'(mem_req), 32'd0);
        ready_mode = 0;
        repeat (2) tick();
        chk("no_store", 32'(store_count - sc0), 32'd0);
        chk("no_store_mem", rd_mem(32'h40), 32'd0);
        reset = 1'b0;
        #1;
        chk("restart_req", 32'(mem_req), 32'd1);
        chk("restart_addr", mem_addr, 32'h100);
        chk("restart_we", 32'(mem_we), 32'd0);
        chk("restart_retired", retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
